// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: RV32I funct3 encodings, FSM states and legality helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    WB   = 1'b1
  } state_e;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Lane select and sign/zero extension of a memory word for RV32I loads.
module load_extend (
  input  logic [31:0] rd,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);
  import load_store_unit_pkg::*;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rd[{addr_lo, 3'b000} +: 8];
    lane_h = rd[{addr_lo[1], 4'b0000} +: 16];
    data   = '0;
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_W:    data = rd;
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end: word indexing, load extension,
// two-cycle sub-word store merge and registered fault reporting.
module load_store_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       Funct3,
  input  logic [31:0]      Addr,
  input  logic [31:0]      StoreData,
  output logic [31:0]      LoadData,
  output logic             Stall,
  output logic             MemWE,
  output logic [31:0]      MemA,
  output logic [31:0]      MemWD,
  input  logic [31:0]      MemRD,
  output logic             Fault,
  output logic [31:0]      FaultAddr,
  output logic [CNT_W-1:0] FaultCount
);
  import load_store_unit_pkg::*;

  localparam int unsigned PAD_W = 32 - ADDR_W;

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] addr_q;
  logic [31:0] word_idx;
  logic [31:0] ext_data;
  logic        is_store, is_load, idle;
  logic        f3_bad, size_bad, range_bad;
  logic        fault_c, sw_go, sub_go, load_go;

  load_extend u_load_extend (
    .rd      (MemRD),
    .funct3  (Funct3),
    .addr_lo (Addr[1:0]),
    .data    (ext_data)
  );

  // Request decode; a simultaneous read+write is treated as a store
  always_comb begin
    idle      = (state_q == IDLE);
    is_store  = MemWrite;
    is_load   = MemRead & ~MemWrite;
    f3_bad    = is_store ? !store_f3_ok(Funct3) : !load_f3_ok(Funct3);
    case (Funct3[1:0])
      2'b01:   size_bad = Addr[0];
      2'b10:   size_bad = |Addr[1:0];
      default: size_bad = 1'b0;
    endcase
    range_bad = |Addr[31:ADDR_W+2];
    fault_c   = idle & (MemRead | MemWrite) & (f3_bad | size_bad | range_bad);
    sw_go     = idle & is_store & ~fault_c & (Funct3 == F3_W);
    sub_go    = idle & is_store & ~fault_c & (Funct3 != F3_W);
    load_go   = idle & is_load & ~fault_c;
    word_idx  = {{PAD_W{1'b0}}, Addr[ADDR_W+1:2]};
  end

  // Replace the addressed byte/half of the current word with store data
  always_comb begin
    merge_d = MemRD;
    if (Funct3 == F3_H) begin
      merge_d[{Addr[1], 4'b0000} +: 16] = StoreData[15:0];
    end else begin
      merge_d[{Addr[1:0], 3'b000} +: 8] = StoreData[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sub_go) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MemWE    = 1'b0;
    MemA     = word_idx;
    MemWD    = StoreData;
    Stall    = 1'b0;
    LoadData = '0;
    case (state_q)
      IDLE: begin
        MemWE = RST & sw_go;
        Stall = sub_go;
        if (load_go) LoadData = ext_data;
      end
      WB: begin
        MemWE = RST;
        MemA  = addr_q;
        MemWD = merge_q;
      end
      default: ;
    endcase
  end

  // Merge holding registers and fault reporting
  always_ff @(posedge CLK) begin
    if (!RST) begin
      merge_q    <= '0;
      addr_q     <= '0;
      Fault      <= 1'b0;
      FaultAddr  <= '0;
      FaultCount <= '0;
    end else begin
      Fault <= fault_c;
      if (fault_c) begin
        FaultAddr  <= Addr;
        FaultCount <= (FaultCount == {CNT_W{1'b1}}) ? FaultCount : FaultCount + CNT_W'(1);
      end
      if (sub_go) begin
        merge_q <= merge_d;
        addr_q  <= word_idx;
      end
    end
  end

endmodule
